// File: rtl/csr_timer_pkg.sv
// Shared constants and types for the CSR timer unit: register map, counter type, reset values.
package csr_timer_pkg;

  localparam int unsigned CNT_W         = 64;
  localparam int unsigned ADDR_CNT_LO   = 0;
  localparam int unsigned ADDR_CNT_HI   = 1;
  localparam int unsigned ADDR_CMP_BASE = 2;

  typedef logic [CNT_W-1:0] count_t;

  localparam count_t CMP_RST = '1;

endpackage

// File: rtl/timer_prescaler.sv
// Programmable prescaler: issues a tick every prescale+1 enabled cycles; clear restarts the period.
module timer_prescaler #(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic                  clear_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;

  // A shrinking divisor below pcnt lets pcnt run on and wrap before matching again.
  always_comb begin
    pcnt_d = pcnt_q;
    tick_o = 1'b0;
    if (clear_i) begin
      pcnt_d = '0;
    end else if (en_i) begin
      if (pcnt_q == prescale_i) begin
        pcnt_d = '0;
        tick_o = 1'b1;
      end else begin
        pcnt_d = pcnt_q + PRESCALE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pcnt_q <= '0;
    else     pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/csr_timer_unit.sv
// 64-bit CSR time counter with prescaler, split bus access, atomic lo/hi read and N compare irqs.
module csr_timer_unit
  import csr_timer_pkg::*;
#(
  parameter int unsigned COUNT_LEN  = CNT_W,
  parameter int unsigned BUS_W      = 32,
  parameter int unsigned PRESCALE_W = 8,
  parameter int unsigned N_CMP      = 2,
  parameter int unsigned ADDR_W     = $clog2(2 + 2 * N_CMP)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [BUS_W-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [BUS_W-1:0]      rd_data,
  output logic [COUNT_LEN-1:0]  count_out,
  output logic                  tick_out,
  output logic [N_CMP-1:0]      irq
);

  logic [COUNT_LEN-1:0]            count_q, count_d;
  logic [BUS_W-1:0]                shadow_q, shadow_d;
  logic [BUS_W-1:0]                rd_data_q, rd_data_d;
  logic                            tick_q;
  logic                            tick;
  logic                            cnt_wr_lo, cnt_wr_hi, cnt_clear;
  logic [N_CMP-1:0][COUNT_LEN-1:0] cmp_all;

  assign cnt_wr_lo = wr_en && (wr_addr == ADDR_W'(ADDR_CNT_LO));
  assign cnt_wr_hi = wr_en && (wr_addr == ADDR_W'(ADDR_CNT_HI));
  assign cnt_clear = cnt_wr_lo || cnt_wr_hi;

  // tick is already suppressed by clear, so a counter write never also increments.
  timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en),
    .prescale_i (prescale),
    .clear_i    (cnt_clear),
    .tick_o     (tick)
  );

  always_comb begin
    count_d = count_q;
    if (tick)      count_d = count_q + COUNT_LEN'(1);
    if (cnt_wr_lo) count_d[BUS_W-1:0] = wr_data;
    if (cnt_wr_hi) count_d[COUNT_LEN-1:BUS_W] = wr_data;
  end

  // Reads see pre-edge state, so a same-cycle write to the read address is not visible yet.
  always_comb begin
    rd_data_d = rd_data_q;
    shadow_d  = shadow_q;
    if (rd_en) begin
      rd_data_d = '0;
      if (rd_addr == ADDR_W'(ADDR_CNT_LO)) begin
        rd_data_d = count_q[BUS_W-1:0];
        shadow_d  = count_q[COUNT_LEN-1:BUS_W];
      end else if (rd_addr == ADDR_W'(ADDR_CNT_HI)) begin
        rd_data_d = shadow_q;
      end
      for (int unsigned k = 0; k < N_CMP; k++) begin
        if (rd_addr == ADDR_W'(ADDR_CMP_BASE + 2 * k))
          rd_data_d = cmp_all[k][BUS_W-1:0];
        if (rd_addr == ADDR_W'(ADDR_CMP_BASE + 2 * k + 1))
          rd_data_d = cmp_all[k][COUNT_LEN-1:BUS_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      shadow_q  <= '0;
      rd_data_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      shadow_q  <= shadow_d;
      rd_data_q <= rd_data_d;
      tick_q    <= tick;
    end
  end

  for (genvar k = 0; k < N_CMP; k++) begin : g_cmp
    localparam logic [ADDR_W-1:0] A_LO = ADDR_W'(ADDR_CMP_BASE + 2 * k);
    localparam logic [ADDR_W-1:0] A_HI = ADDR_W'(ADDR_CMP_BASE + 2 * k + 1);

    logic [COUNT_LEN-1:0] cmp_q, cmp_d;
    logic                 irq_q;

    always_comb begin
      cmp_d = cmp_q;
      if (wr_en && (wr_addr == A_LO)) cmp_d[BUS_W-1:0] = wr_data;
      if (wr_en && (wr_addr == A_HI)) cmp_d[COUNT_LEN-1:BUS_W] = wr_data;
    end

    // Comparing next-state values keeps irq aligned with the count_out it refers to.
    always_ff @(posedge clk) begin
      if (rst) begin
        cmp_q <= {COUNT_LEN{CMP_RST[0]}};
        irq_q <= 1'b0;
      end else begin
        cmp_q <= cmp_d;
        irq_q <= (count_d >= cmp_d);
      end
    end

    assign cmp_all[k] = cmp_q;
    assign irq[k]     = irq_q;
  end

  assign count_out = count_q;
  assign tick_out  = tick_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_csr_timer_unit.sv
// Scoreboard bench for csr_timer_unit: driver updates a reference model, monitor compares every cycle.
module tb_csr_timer_unit;
  import csr_timer_pkg::*;

  localparam int unsigned NC = 2;

  logic          clk = 1'b0;
  logic          rst, en, wr_en, rd_en;
  logic [7:0]    prescale;
  logic [2:0]    wr_addr, rd_addr;
  logic [31:0]   wr_data, rd_data;
  count_t        count_out;
  logic          tick_out;
  logic [NC-1:0] irq;

  always #5 clk = ~clk;

  csr_timer_unit #(
    .COUNT_LEN  (64),
    .BUS_W      (32),
    .PRESCALE_W (8),
    .N_CMP      (NC),
    .ADDR_W     (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .prescale  (prescale),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .count_out (count_out),
    .tick_out  (tick_out),
    .irq       (irq)
  );

  typedef struct {
    count_t        cnt;
    logic          tick;
    logic [NC-1:0] irq;
    logic [31:0]   rd;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state
  count_t        m_cnt;
  int unsigned   m_pcnt;
  count_t        m_cmp [NC];
  logic [31:0]   m_shadow, m_rd;
  logic          m_tick;
  logic [NC-1:0] m_irq;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [7:0] ps,
                      input logic we, input logic [2:0] wa, input logic [31:0] wd,
                      input logic re, input logic [2:0] ra);
    exp_t   x;
    count_t nxt;
    int     idx;
    @(negedge clk);
    rst = r; en = e; prescale = ps;
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra;
    if (r) begin
      m_cnt = '0; m_pcnt = 0; m_shadow = '0; m_rd = '0; m_tick = 1'b0; m_irq = '0;
      for (int k = 0; k < NC; k++) m_cmp[k] = '1;
    end else begin
      if (re) begin
        if (ra == 3'd0) begin
          m_rd = m_cnt[31:0];
          m_shadow = m_cnt[63:32];
        end else if (ra == 3'd1) begin
          m_rd = m_shadow;
        end else if (int'(ra) < 2 + 2 * NC) begin
          idx = (int'(ra) - 2) / 2;
          m_rd = ra[0] ? m_cmp[idx][63:32] : m_cmp[idx][31:0];
        end else begin
          m_rd = '0;
        end
      end
      nxt = m_cnt;
      m_tick = 1'b0;
      if (we && int'(wa) < 2) begin
        m_pcnt = 0;
        if (wa == 3'd0) nxt[31:0] = wd;
        else            nxt[63:32] = wd;
      end else if (e) begin
        if (m_pcnt == int'(ps)) begin
          m_pcnt = 0;
          m_tick = 1'b1;
          nxt = m_cnt + 64'd1;
        end else begin
          m_pcnt = (m_pcnt + 1) % 256;
        end
      end
      if (we && int'(wa) >= 2 && int'(wa) < 2 + 2 * NC) begin
        idx = (int'(wa) - 2) / 2;
        if (wa[0]) m_cmp[idx][63:32] = wd;
        else       m_cmp[idx][31:0]  = wd;
      end
      m_cnt = nxt;
      for (int k = 0; k < NC; k++) m_irq[k] = (m_cnt >= m_cmp[k]);
    end
    x.cnt = m_cnt; x.tick = m_tick; x.irq = m_irq; x.rd = m_rd;
    sb.push_back(x);
  endtask

  task automatic idle(input logic e, input logic [7:0] ps);
    step(1'b0, e, ps, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic e, input logic [7:0] ps);
    step(1'b0, e, ps, 1'b1, a, d, 1'b0, 3'd0);
  endtask

  task automatic rd(input logic [2:0] a, input logic e, input logic [7:0] ps);
    step(1'b0, e, ps, 1'b0, 3'd0, 32'd0, 1'b1, a);
  endtask

  task automatic post();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compares the DUT against the oldest expected entry after every edge.
  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check("count_out", count_out, x.cnt);
        check("tick_out", 64'(tick_out), 64'(x.tick));
        check("irq", 64'(irq), 64'(x.irq));
        check("rd_data", 64'(rd_data), 64'(x.rd));
      end
    end
  end

  initial begin : driver
    logic [7:0] ps;
    rst = 1'b1; en = 1'b0; prescale = '0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; rd_en = 1'b0; rd_addr = '0;

    // Reset with random traffic
    repeat (5) step(1'b1, 1'($urandom), 8'($urandom), 1'($urandom), 3'($urandom),
                    $urandom, 1'($urandom), 3'($urandom));
    post();
    check("rst_count", count_out, 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    rd(3'd2, 1'b0, 8'd0);
    post();
    check("rst_cmp0_lo", 64'(rd_data), 64'hFFFF_FFFF);

    // Prescaler = 3
    for (int i = 0; i < 16; i++) begin
      idle(1'b1, 8'd3);
      post();
      check("presc_tick", 64'(tick_out), (i % 4 == 3) ? 64'd1 : 64'd0);
    end
    check("presc_count", count_out, 64'd4);
    repeat (5) idle(1'b0, 8'd3);
    post();
    check("presc_hold", count_out, 64'd4);

    // Split write and wrap
    wr(3'd1, 32'hFFFF_FFFF, 1'b1, 8'd0);
    wr(3'd0, 32'hFFFF_FFFE, 1'b1, 8'd0);
    post();
    check("wrap_load", count_out, 64'hFFFF_FFFF_FFFF_FFFE);
    idle(1'b1, 8'd0);
    post();
    check("wrap_ffff", count_out, 64'hFFFF_FFFF_FFFF_FFFF);
    idle(1'b1, 8'd0);
    post();
    check("wrap_zero", count_out, 64'd0);
    check("wrap_tick", 64'(tick_out), 64'd1);

    // Atomic lo/hi read
    wr(3'd1, 32'h0000_0001, 1'b0, 8'd0);
    wr(3'd0, 32'hFFFF_FFFF, 1'b0, 8'd0);
    rd(3'd0, 1'b1, 8'd0);
    post();
    check("atomic_lo", 64'(rd_data), 64'hFFFF_FFFF);
    rd(3'd1, 1'b1, 8'd0);
    post();
    check("atomic_hi", 64'(rd_data), 64'h0000_0001);
    check("atomic_cnt", count_out, 64'h0000_0002_0000_0001);

    // Compare interrupts
    wr(3'd2, 32'd100, 1'b0, 8'd0);
    wr(3'd3, 32'd0,   1'b0, 8'd0);
    wr(3'd4, 32'd200, 1'b0, 8'd0);
    wr(3'd5, 32'd0,   1'b0, 8'd0);
    wr(3'd1, 32'd0,   1'b0, 8'd0);
    wr(3'd0, 32'd0,   1'b0, 8'd0);
    repeat (99) idle(1'b1, 8'd0);
    post();
    check("irq_99", 64'(irq), 64'b00);
    idle(1'b1, 8'd0);
    post();
    check("irq_100_cnt", count_out, 64'd100);
    check("irq_100", 64'(irq), 64'b01);
    repeat (99) idle(1'b1, 8'd0);
    post();
    check("irq_199", 64'(irq), 64'b01);
    idle(1'b1, 8'd0);
    post();
    check("irq_200", 64'(irq), 64'b11);
    wr(3'd2, 32'd1000, 1'b1, 8'd0);
    post();
    check("irq_cmp_raise", 64'(irq), 64'b10);

    // Counter write overrides a scheduled tick
    wr(3'd0, 32'd0, 1'b1, 8'd3);
    repeat (3) idle(1'b1, 8'd3);
    wr(3'd0, 32'd50, 1'b1, 8'd3);
    post();
    check("ovr_count", count_out, 64'd50);
    check("ovr_tick", 64'(tick_out), 64'd0);
    repeat (3) idle(1'b1, 8'd3);
    post();
    check("ovr_wait", count_out, 64'd50);
    idle(1'b1, 8'd3);
    post();
    check("ovr_next", count_out, 64'd51);
    check("ovr_next_tick", 64'(tick_out), 64'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      ps = ($urandom_range(7, 0) == 0) ? 8'($urandom) : 8'($urandom_range(3, 0));
      step(1'($urandom_range(63, 0) == 0), 1'($urandom_range(3, 0) != 0), ps,
           1'($urandom_range(3, 0) == 0), 3'($urandom),
           ($urandom_range(1, 0) == 1) ? 32'($urandom_range(300, 0)) : $urandom,
           1'($urandom_range(1, 0)), 3'($urandom));
    end

    post();
    post();
    if (sb.size() != 0) check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
